timer_unit: RTL and testbench
=============================

# timer_unit

General-purpose 16-bit up-counting timer, directly downstream of the datapath unit. Consumes the datapath's TIM_PSC and TIM_ARR register outputs through a prescaler stage and a main counter. Generates a one-cycle update event and a sticky update interrupt flag on every auto-reload wrap, with optional ARR preload and one-pulse modes.

## Interface
- TIM_W, 16, width of the prescaler, auto-reload and counter values
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- tim_psc  in  TIM_W  prescaler value from the datapath TIM_PSC register; divide ratio is tim_psc+1
- tim_arr  in  TIM_W  auto-reload value from the datapath TIM_ARR register
- tim_en  in  1  counter enable, level-sensitive
- arpe  in  1  ARR preload enable: 1 = ARR taken only at update/start, 0 = ARR followed every cycle
- one_pulse  in  1  1 = stop after the first update event
- irq_clr  in  1  clears uif
- cnt  out  TIM_W  current main counter value
- update_evt  out  1  one-cycle pulse on auto-reload wrap
- uif  out  1  sticky update interrupt flag
- running  out  1  high while the FSM is in TIM_RUN

## Operation
- FSM states:
  - TIM_IDLE: counters cleared and held.
  - TIM_RUN: counting.
  - TIM_HALT: one-pulse done; waits for tim_en low.
- Transitions:
  - IDLE→RUN when tim_en=1.
  - RUN→IDLE when tim_en=0; cnt and psc_cnt clear, with no update.
  - RUN→HALT on an update event when one_pulse=1.
  - HALT→IDLE when tim_en=0.
- On IDLE→RUN:
  - psc_sh←tim_psc, arr_sh←tim_arr.
  - psc_cnt←0, cnt←0.
- Prescaler:
  - psc_cnt counts 0..psc_sh.
  - tick asserts when psc_cnt==psc_sh, and psc_cnt then returns to 0.
  - psc_sh=0 gives a tick every cycle.
- Main counter, on each tick:
  - if cnt ≥ arr_sh: cnt←0 and update_evt fires.
  - else: cnt←cnt+1.
  - The ≥ compare guarantees a wrap when ARR shrinks below cnt; the counter never rolls past 0xFFFF.
- arr_sh=0: an update fires on every tick and cnt stays 0.
- On an update event:
  - psc_sh←tim_psc.
  - if arpe=1: arr_sh←tim_arr.
  - PSC is always preloaded; a new PSC takes effect only from the next period.
- arpe=0: arr_sh←tim_arr every cycle in RUN, one cycle of latency.
- uif:
  - set on update_evt; held until irq_clr.
  - simultaneous set and clear: set wins.
- In HALT:
  - cnt holds 0; uif is retained; update_evt stays low.
  - tim_en remaining high does not restart the timer.
- All arithmetic is unsigned, TIM_W bits, with no carry out.
- The upstream TIM_ARR register has no reset value; software/bench writes it before the first enable.

## Timing
- Reset values: cnt=0, update_evt=0, uif=0, running=0, state=TIM_IDLE, psc_sh=0, arr_sh=0, psc_cnt=0.
- Reset is asynchronous and overrides everything, including mid-count and HALT.
- tim_en sampled high at edge N: running=1 and cnt=0 after edge N. The first tick is at edge N+1+psc_sh.
- update_evt is registered and high for exactly one cycle, in the same cycle cnt reads 0 after the wrap.
- uif rises in the same cycle as update_evt.
- Update period: (psc_sh+1)·(arr_sh+1) cycles. First update: (psc+1)·(arr+1) cycles after the enable edge.
- irq_clr: uif is low the cycle after the irq_clr edge.
- tim_en low at edge M: running=0 and cnt=0 after edge M. A pending tick at edge M is discarded.

## Structure
- Package tim_pkg holds:
  - TIM_W = 16.
  - typedef enum tim_state_t {TIM_IDLE, TIM_RUN, TIM_HALT}.
- Sub-module tim_prescaler (psc_sh register, psc_cnt, tick output, load/clear inputs) is instantiated once.
- The FSM, main counter, ARR shadow and flags live in timer_unit.

## Test plan
- Basic period: reset, psc=1, arr=3, arpe=1, tim_en=1 → cnt steps 0,1,2,3 every 2 cycles; update_evt every 8 cycles; uif set at the first update.
- ARR preload: arpe=1 running at arr=9; write tim_arr=4 when cnt=2 → count continues to 9, wraps, then period 5. Repeat with arpe=0 → wraps as soon as cnt≥4 on the next tick.
- Shrink-below-count: arpe=0, psc=0, arr=20, cnt=15; set tim_arr=10 → cnt 15→0 on the next tick with update_evt.
- One-pulse: one_pulse=1, psc=0, arr=5 → single update at cycle 6; running=0, cnt=0, stays in HALT while tim_en=1; tim_en 0→1 restarts.
- Flag race: irq_clr asserted in the same cycle as update_evt → uif remains 1; irq_clr alone one cycle later → uif=0.
- Async reset: reset pulsed mid-count (cnt=7, uif=1) between clock edges → all outputs 0 immediately; with tim_en still high, counting restarts from 0 after reset release.

Source files
------------

// File: rtl/tim_pkg.sv
// Shared types and width for the general-purpose timer.
package tim_pkg;

    localparam int TIM_W = 16;

    typedef enum logic [1:0] {
        TIM_IDLE,
        TIM_RUN,
        TIM_HALT
    } tim_state_t;

endpackage

// File: rtl/tim_prescaler.sv
// Prescaler for timer_unit: divides the clock by psc_sh+1 and emits a tick.
module tim_prescaler
    import tim_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [TIM_W-1:0] psc_in,
    output logic             tick
);

    logic [TIM_W-1:0] psc_sh_q, psc_sh_d;
    logic [TIM_W-1:0] psc_cnt_q, psc_cnt_d;

    assign tick = en && (psc_cnt_q == psc_sh_q);

    // load happens at start or on an update, which always coincides with a tick
    always_comb begin
        psc_sh_d  = psc_sh_q;
        psc_cnt_d = psc_cnt_q;
        if (load) begin
            psc_sh_d  = psc_in;
            psc_cnt_d = '0;
        end else if (!en || tick) begin
            psc_cnt_d = '0;
        end else begin
            psc_cnt_d = psc_cnt_q + TIM_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_sh_q  <= '0;
            psc_cnt_q <= '0;
        end else begin
            psc_sh_q  <= psc_sh_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: rtl/timer_unit.sv
// 16-bit up-counting timer with prescaler, ARR preload, one-pulse mode,
// a registered update event and a sticky update interrupt flag.
module timer_unit
    import tim_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [TIM_W-1:0] tim_psc,
    input  logic [TIM_W-1:0] tim_arr,
    input  logic             tim_en,
    input  logic             arpe,
    input  logic             one_pulse,
    input  logic             irq_clr,
    output logic [TIM_W-1:0] cnt,
    output logic             update_evt,
    output logic             uif,
    output logic             running
);

    tim_state_t       state_q, state_d;
    logic [TIM_W-1:0] cnt_q, cnt_d;
    logic [TIM_W-1:0] arr_sh_q, arr_sh_d;
    logic             update_evt_q, update_evt_d;
    logic             uif_q, uif_d;

    logic start;
    logic counting;
    logic tick;
    logic wrap;

    assign start    = (state_q == TIM_IDLE) && tim_en;
    assign counting = (state_q == TIM_RUN) && tim_en;
    // >= rather than == so a shrunken ARR below cnt still wraps
    assign wrap     = tick && (cnt_q >= arr_sh_q);

    tim_prescaler u_psc (
        .clk    (clk),
        .reset  (reset),
        .load   (start || wrap),
        .en     (counting),
        .psc_in (tim_psc),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        arr_sh_d = arr_sh_q;
        unique case (state_q)
            TIM_IDLE: begin
                cnt_d = '0;
                if (tim_en) begin
                    state_d  = TIM_RUN;
                    arr_sh_d = tim_arr;
                end
            end
            TIM_RUN: begin
                if (!arpe) arr_sh_d = tim_arr;
                if (!tim_en) begin
                    state_d = TIM_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    cnt_d = '0;
                    if (arpe) arr_sh_d = tim_arr;
                    if (one_pulse) state_d = TIM_HALT;
                end else if (tick) begin
                    cnt_d = cnt_q + TIM_W'(1);
                end
            end
            TIM_HALT: begin
                cnt_d = '0;
                if (!tim_en) state_d = TIM_IDLE;
            end
            default: begin
                state_d = TIM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // set wins over a simultaneous clear
    always_comb begin
        update_evt_d = wrap;
        uif_d        = wrap || (uif_q && !irq_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= TIM_IDLE;
            cnt_q        <= '0;
            arr_sh_q     <= '0;
            update_evt_q <= 1'b0;
            uif_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            arr_sh_q     <= arr_sh_d;
            update_evt_q <= update_evt_d;
            uif_q        <= uif_d;
        end
    end

    assign cnt        = cnt_q;
    assign update_evt = update_evt_q;
    assign uif        = uif_q;
    assign running    = (state_q == TIM_RUN);

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: table of period vectors with an
// update-time scoreboard, plus directed multi-cycle corner sequences.
module tb_timer_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tim_psc;
    logic [15:0] tim_arr;
    logic        tim_en;
    logic        arpe;
    logic        one_pulse;
    logic        irq_clr;
    logic [15:0] cnt;
    logic        update_evt;
    logic        uif;
    logic        running;

    timer_unit dut (
        .clk        (clk),
        .reset      (reset),
        .tim_psc    (tim_psc),
        .tim_arr    (tim_arr),
        .tim_en     (tim_en),
        .arpe       (arpe),
        .one_pulse  (one_pulse),
        .irq_clr    (irq_clr),
        .cnt        (cnt),
        .update_evt (update_evt),
        .uif        (uif),
        .running    (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] psc;
        logic [15:0] arr;
        int          n_upd;
        int          period;
    } vec_t;

    vec_t vecs[5];
    int   ncmp  = 0;
    int   nfail = 0;
    int   cyc   = 0;
    bit   sb_on = 1'b0;
    int   sbq[$];

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sb_on && update_evt) begin
            if (sbq.size() == 0) begin
                chk("sb_spurious_update", 1, 0);
            end else begin
                int e;
                e = sbq.pop_front();
                chk("sb_update_time", cyc, e);
                chk("sb_cnt_at_update", int'(cnt), 0);
            end
        end
    endtask

    task automatic wait_cnt(input int val, input string name);
        int found = 0;
        for (int i = 0; i < 200; i++) begin
            if (int'(cnt) == val) begin
                found = 1;
                break;
            end
            step();
        end
        chk(name, found, 1);
    endtask

    task automatic wait_upd(input string name);
        int found = 0;
        for (int i = 0; i < 200; i++) begin
            if (update_evt) begin
                found = 1;
                break;
            end
            step();
        end
        chk(name, found, 1);
    endtask

    task automatic stop_and_clear();
        tim_en  = 1'b0;
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        chk("stop_running", int'(running), 0);
        chk("stop_cnt", int'(cnt), 0);
        chk("stop_uif", int'(uif), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int k, p, a, per, hcount, rcount;

        vecs[0] = '{psc: 16'd1, arr: 16'd3, n_upd: 3, period: 8};
        vecs[1] = '{psc: 16'd0, arr: 16'd0, n_upd: 4, period: 1};
        vecs[2] = '{psc: 16'd0, arr: 16'd5, n_upd: 3, period: 6};
        vecs[3] = '{psc: 16'd2, arr: 16'd4, n_upd: 2, period: 15};
        vecs[4] = '{psc: 16'd3, arr: 16'd0, n_upd: 3, period: 4};

        reset     = 1'b1;
        tim_psc   = '0;
        tim_arr   = '0;
        tim_en    = 1'b0;
        arpe      = 1'b1;
        one_pulse = 1'b0;
        irq_clr   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_update_evt", int'(update_evt), 0);
        chk("rst_uif", int'(uif), 0);
        chk("rst_running", int'(running), 0);
        reset = 1'b0;
        step();
        chk("idle_running", int'(running), 0);

        // Table-driven periods with scoreboard on update times
        for (int v = 0; v < 5; v++) begin
            p   = int'(vecs[v].psc);
            a   = int'(vecs[v].arr);
            per = vecs[v].period;
            tim_psc = vecs[v].psc;
            tim_arr = vecs[v].arr;
            arpe    = 1'b1;
            stop_and_clear();
            tim_en = 1'b1;
            k = cyc;
            for (int i = 1; i <= vecs[v].n_upd; i++) sbq.push_back(k + 1 + per * i);
            sb_on = 1'b1;
            for (int s = 0; s < per * vecs[v].n_upd + 1; s++) begin
                step();
                chk("vec_cnt", int'(cnt), ((cyc - k - 1) / (p + 1)) % (a + 1));
                chk("vec_running", int'(running), 1);
                chk("vec_uif", int'(uif), ((cyc - k - 1) >= per) ? 1 : 0);
            end
            sb_on = 1'b0;
            chk("sb_missed_updates", sbq.size(), 0);
            sbq.delete();
        end

        // ARR preload, arpe=1: new ARR only after the current period
        tim_psc = 16'd0;
        tim_arr = 16'd9;
        arpe    = 1'b1;
        stop_and_clear();
        tim_en = 1'b1;
        step();
        wait_cnt(2, "pre1_reach2");
        tim_arr = 16'd4;
        for (int i = 3; i <= 9; i++) begin
            step();
            chk("pre1_cnt", int'(cnt), i);
        end
        step();
        chk("pre1_wrap_cnt", int'(cnt), 0);
        chk("pre1_wrap_upd", int'(update_evt), 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("pre1_cnt2", int'(cnt), i);
            chk("pre1_upd_low", int'(update_evt), 0);
        end
        step();
        chk("pre1_wrap2_upd", int'(update_evt), 1);
        chk("pre1_wrap2_cnt", int'(cnt), 0);

        // ARR direct, arpe=0: new ARR followed with one cycle of latency
        tim_arr = 16'd9;
        arpe    = 1'b0;
        stop_and_clear();
        tim_en = 1'b1;
        step();
        wait_cnt(2, "pre0_reach2");
        tim_arr = 16'd4;
        step();
        chk("pre0_cnt3", int'(cnt), 3);
        step();
        chk("pre0_cnt4", int'(cnt), 4);
        chk("pre0_upd_low", int'(update_evt), 0);
        step();
        chk("pre0_wrap_cnt", int'(cnt), 0);
        chk("pre0_wrap_upd", int'(update_evt), 1);
        for (int i = 1; i <= 4; i++) step();
        chk("pre0_cnt4b", int'(cnt), 4);
        step();
        chk("pre0_wrap2_upd", int'(update_evt), 1);

        // Shrink below count
        tim_arr = 16'd20;
        arpe    = 1'b0;
        stop_and_clear();
        tim_en = 1'b1;
        step();
        wait_cnt(14, "shr_reach14");
        tim_arr = 16'd10;
        step();
        chk("shr_cnt15", int'(cnt), 15);
        chk("shr_upd_low", int'(update_evt), 0);
        step();
        chk("shr_wrap_cnt", int'(cnt), 0);
        chk("shr_wrap_upd", int'(update_evt), 1);
        chk("shr_uif", int'(uif), 1);

        // One-pulse
        tim_arr   = 16'd5;
        arpe      = 1'b1;
        one_pulse = 1'b1;
        stop_and_clear();
        tim_en = 1'b1;
        step();
        chk("op_start_running", int'(running), 1);
        chk("op_start_cnt", int'(cnt), 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("op_cnt", int'(cnt), i);
            chk("op_upd_low", int'(update_evt), 0);
        end
        step();
        chk("op_upd", int'(update_evt), 1);
        chk("op_cnt0", int'(cnt), 0);
        chk("op_running_low", int'(running), 0);
        chk("op_uif", int'(uif), 1);
        hcount = 0;
        rcount = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            hcount += int'(update_evt);
            rcount += int'(running) + (cnt != 0 ? 1 : 0);
        end
        chk("op_halt_updates", hcount, 0);
        chk("op_halt_run_or_cnt", rcount, 0);
        chk("op_halt_uif", int'(uif), 1);
        tim_en = 1'b0;
        step();
        chk("op_idle_running", int'(running), 0);
        tim_en = 1'b1;
        step();
        chk("op_restart_running", int'(running), 1);
        chk("op_restart_cnt", int'(cnt), 0);
        step();
        chk("op_restart_cnt1", int'(cnt), 1);
        one_pulse = 1'b0;

        // Flag race: clear at the setting edge loses, clear alone wins
        tim_arr = 16'd3;
        stop_and_clear();
        tim_en = 1'b1;
        step();
        wait_cnt(3, "race_reach3");
        irq_clr = 1'b1;
        step();
        chk("race_upd", int'(update_evt), 1);
        chk("race_set_wins", int'(uif), 1);
        step();
        chk("race_clr_alone", int'(uif), 0);
        chk("race_upd_low", int'(update_evt), 0);
        irq_clr = 1'b0;

        // Async reset mid-count
        tim_arr = 16'd9;
        stop_and_clear();
        tim_en = 1'b1;
        step();
        wait_upd("ar_first_update");
        wait_cnt(7, "ar_reach7");
        chk("ar_pre_uif", int'(uif), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_cnt", int'(cnt), 0);
        chk("ar_uif", int'(uif), 0);
        chk("ar_running", int'(running), 0);
        chk("ar_upd", int'(update_evt), 0);
        step();
        chk("ar_held_cnt", int'(cnt), 0);
        reset = 1'b0;
        step();
        chk("ar_restart_running", int'(running), 1);
        chk("ar_restart_cnt", int'(cnt), 0);
        step();
        chk("ar_restart_cnt1", int'(cnt), 1);
        step();
        chk("ar_restart_cnt2", int'(cnt), 2);

        tim_en = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
